// File: rtl/pc_sequencer_if.sv
// Core-side bundle for the next-PC/stall sequencer: control inputs, PC outputs,
// state and performance counters.
interface pc_sequencer_if #(
    parameter int ADDR_W = 64
);
    logic [ADDR_W-1:0] i_pc_cur;
    logic              i_imem_ready;
    logic              i_load_use_hazard;
    logic              i_branch_taken;
    logic [ADDR_W-1:0] i_branch_target;
    logic              i_trap_req;
    logic              i_halt_req;
    logic              i_resume;
    logic [ADDR_W-1:0] o_pc_next;
    logic              o_pc_stall;
    logic              o_flush_ifid;
    logic              o_flush_idex;
    logic [1:0]        o_seq_state;
    logic [31:0]       o_stall_cycles;
    logic [31:0]       o_redirect_cnt;

    modport master (
        output i_pc_cur, i_imem_ready, i_load_use_hazard, i_branch_taken,
               i_branch_target, i_trap_req, i_halt_req, i_resume,
        input  o_pc_next, o_pc_stall, o_flush_ifid, o_flush_idex,
               o_seq_state, o_stall_cycles, o_redirect_cnt
    );

    modport slave (
        input  i_pc_cur, i_imem_ready, i_load_use_hazard, i_branch_taken,
               i_branch_target, i_trap_req, i_halt_req, i_resume,
        output o_pc_next, o_pc_stall, o_flush_ifid, o_flush_idex,
               o_seq_state, o_stall_cycles, o_redirect_cnt
    );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC and stall controller: arbitrates trap/branch redirects, hazards and
// debug halt, parks a redirect target while imem is busy, counts stalls/redirects.
module pc_sequencer #(
    parameter int                ADDR_W       = 64,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter logic [ADDR_W-1:0] TRAP_VECTOR  = 'h100,
    parameter int                INSTR_BYTES  = 4
) (
    input logic           i_clk,
    input logic           i_reset,
    pc_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_RUN      = 2'b00,
        S_REDIRECT = 2'b01,
        S_HALTED   = 2'b10
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pend;
    logic [31:0]       r_stall_cnt;
    logic [31:0]       r_redir_cnt;

    state_t            w_nstate;
    logic [ADDR_W-1:0] w_pend_nxt;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] w_tgt;
    logic              w_stall;
    logic              w_flush_ifid;
    logic              w_flush_idex;
    logic              w_redir_inc;
    logic              w_evt;

    // Trap beats branch; in HALTED only a trap can start a redirect event.
    assign w_tgt = bus.i_trap_req ? TRAP_VECTOR : bus.i_branch_target;
    assign w_evt = bus.i_trap_req | (bus.i_branch_taken & (r_state == S_RUN));

    always_comb begin
        w_nstate     = r_state;
        w_pend_nxt   = r_pend;
        w_pc_next    = bus.i_pc_cur;
        w_stall      = 1'b0;
        w_flush_ifid = 1'b0;
        w_flush_idex = 1'b0;
        w_redir_inc  = 1'b0;
        case (r_state)
            S_REDIRECT: begin
                // Wrong-path branch/hazard/halt are ignored; only a trap retargets.
                w_pc_next    = bus.i_trap_req ? TRAP_VECTOR : r_pend;
                w_pend_nxt   = w_pc_next;
                w_stall      = !bus.i_imem_ready;
                w_flush_ifid = 1'b1;
                w_redir_inc  = bus.i_trap_req;
                if (bus.i_imem_ready) w_nstate = S_RUN;
            end
            S_RUN, S_HALTED: begin
                if (w_evt) begin
                    w_flush_ifid = 1'b1;
                    w_flush_idex = 1'b1;
                    w_redir_inc  = 1'b1;
                    if (bus.i_imem_ready) begin
                        w_pc_next = w_tgt;
                        w_nstate  = S_RUN;
                    end else begin
                        w_stall    = 1'b1;
                        w_pend_nxt = w_tgt;
                        w_nstate   = S_REDIRECT;
                    end
                end else if (r_state == S_HALTED) begin
                    w_stall = 1'b1;
                    if (bus.i_resume) w_nstate = S_RUN;
                end else if (bus.i_halt_req) begin
                    w_stall  = 1'b1;
                    w_nstate = S_HALTED;
                end else if (bus.i_load_use_hazard || !bus.i_imem_ready) begin
                    w_stall      = 1'b1;
                    w_flush_idex = bus.i_load_use_hazard;
                end else begin
                    w_pc_next = bus.i_pc_cur + ADDR_W'(INSTR_BYTES);
                end
            end
            default: w_nstate = S_RUN;
        endcase
        if (i_reset) begin
            w_pc_next    = RESET_VECTOR;
            w_stall      = 1'b1;
            w_flush_ifid = 1'b1;
            w_flush_idex = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_RUN;
            r_pend      <= RESET_VECTOR;
            r_stall_cnt <= '0;
            r_redir_cnt <= '0;
        end else begin
            r_state <= w_nstate;
            r_pend  <= w_pend_nxt;
            if (w_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_redir_inc && r_redir_cnt != '1) r_redir_cnt <= r_redir_cnt + 32'd1;
        end
    end

    assign bus.o_pc_next      = w_pc_next;
    assign bus.o_pc_stall     = w_stall;
    assign bus.o_flush_ifid   = w_flush_ifid;
    assign bus.o_flush_idex   = w_flush_idex;
    assign bus.o_seq_state    = r_state;
    assign bus.o_stall_cycles = r_stall_cnt;
    assign bus.o_redirect_cnt = r_redir_cnt;
endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized + directed bench for pc_sequencer: a behavioural model pushes expected
// outputs into a queue, a monitor pops and compares each cycle.
module tb_pc_sequencer;
    localparam logic [63:0] TRAP = 64'h100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_sequencer_if #(.ADDR_W(64)) sif ();

    pc_sequencer #(.ADDR_W(64)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (sif.slave)
    );

    typedef struct {
        logic [63:0] pc_next;
        logic        stall;
        logic        fi;
        logic        fe;
        logic [1:0]  st;
        logic [31:0] sc;
        logic [31:0] rc;
        bit          known;
    } exp_t;

    exp_t q[$];
    event ev_chk;
    int   errors = 0;
    int   checks = 0;

    // Model: mode 0 running, 1 waiting to redirect, 2 halted
    bit          mknown = 0;
    int          mmode  = 0;
    logic [63:0] mpend  = '0;
    logic [63:0] mpc    = '0;
    logic [31:0] msc    = '0;
    logic [31:0] mrc    = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    always begin
        exp_t e;
        @(ev_chk);
        #1;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL queue_empty got=0 exp=1");
        end else begin
            e = q.pop_front();
            chk("pc_next", sif.o_pc_next, e.pc_next);
            chk("pc_stall", 64'(sif.o_pc_stall), 64'(e.stall));
            chk("flush_ifid", 64'(sif.o_flush_ifid), 64'(e.fi));
            chk("flush_idex", 64'(sif.o_flush_idex), 64'(e.fe));
            if (e.known) begin
                chk("seq_state", 64'(sif.o_seq_state), 64'(e.st));
                chk("stall_cycles", 64'(sif.o_stall_cycles), 64'(e.sc));
                chk("redirect_cnt", 64'(sif.o_redirect_cnt), 64'(e.rc));
            end
        end
    end

    task automatic step(input bit r, input bit rdy, input bit lu, input bit br,
                        input logic [63:0] bt, input bit tr, input bit hl, input bit rs);
        exp_t        e;
        int          nmode;
        logic [63:0] npend;
        logic [63:0] tgt;
        @(negedge clk);
        rst                   = r;
        sif.i_pc_cur          = mpc;
        sif.i_imem_ready      = rdy;
        sif.i_load_use_hazard = lu;
        sif.i_branch_taken    = br;
        sif.i_branch_target   = bt;
        sif.i_trap_req        = tr;
        sif.i_halt_req        = hl;
        sif.i_resume          = rs;
        e.known = mknown; e.st = 2'(mmode); e.sc = msc; e.rc = mrc;
        e.pc_next = mpc; e.stall = 0; e.fi = 0; e.fe = 0;
        nmode = mmode; npend = mpend;
        if (r) begin
            e.pc_next = '0; e.stall = 1; e.fi = 1; e.fe = 1;
        end else if (mmode == 1) begin
            tgt = tr ? TRAP : mpend;
            e.pc_next = tgt; e.stall = !rdy; e.fi = 1;
            npend = tgt;
            if (tr) e.rc = 0;  // marker; counted below
            if (rdy) nmode = 0;
        end else if (tr || (br && mmode == 0)) begin
            tgt = tr ? TRAP : bt;
            e.fi = 1; e.fe = 1;
            if (rdy) begin e.pc_next = tgt; nmode = 0; end
            else begin e.stall = 1; npend = tgt; nmode = 1; end
        end else if (mmode == 2) begin
            e.stall = 1;
            if (rs) nmode = 0;
        end else if (hl) begin
            e.stall = 1; nmode = 2;
        end else if (lu || !rdy) begin
            e.stall = 1; e.fe = lu;
        end else begin
            e.pc_next = mpc + 64'd4;
        end
        e.rc = mrc;
        q.push_back(e);
        -> ev_chk;
        // Advance the model to the state after this clock edge
        if (r) begin
            mknown = 1; mmode = 0; mpend = '0; msc = '0; mrc = '0; mpc = '0;
        end else begin
            if (e.stall && msc != 32'hFFFF_FFFF) msc++;
            if ((tr || (br && mmode == 0)) && mrc != 32'hFFFF_FFFF) mrc++;
            mmode = nmode; mpend = npend;
            if (!e.stall) mpc = e.pc_next;
        end
    endtask

    initial begin
        rst = 1'b1;
        sif.i_pc_cur = '0; sif.i_imem_ready = 1'b1; sif.i_load_use_hazard = 1'b0;
        sif.i_branch_taken = 1'b0; sif.i_branch_target = '0; sif.i_trap_req = 1'b0;
        sif.i_halt_req = 1'b0; sif.i_resume = 1'b0;
        // reset then sequential fetch 0,4,8,...
        repeat (3) step(1, 1, 0, 0, 0, 0, 0, 0);
        repeat (5) step(0, 1, 0, 0, 0, 0, 0, 0);
        // load-use hold at 0x40
        mpc = 64'h40;
        step(0, 1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        // taken branch, imem ready
        step(0, 1, 0, 1, 64'h200, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        // taken branch with imem busy for 3 cycles
        step(0, 0, 0, 1, 64'h300, 0, 0, 0);
        step(0, 0, 1, 1, 64'h500, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        // trap overrides a pending redirect
        step(0, 0, 0, 1, 64'h300, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        // halt wins over same-cycle resume, then resume
        step(0, 1, 0, 0, 0, 0, 1, 1);
        step(0, 1, 0, 1, 64'h700, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 1);
        // PC wrap
        mpc = 64'hFFFF_FFFF_FFFF_FFFC;
        step(0, 1, 0, 0, 0, 0, 0, 0);
        // trap out of HALTED with imem busy
        step(0, 1, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        // reset while a redirect is pending
        step(0, 0, 0, 1, 64'h880, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) mpc = {$urandom(), $urandom()};
            step($urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                 {$urandom(), $urandom()}, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
        end
        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got=%0d exp=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
